pipe_hazard_ctrl: RTL

- Central sequencer for the F/D/E/W pipeline.
- Each cycle it produces the 2-bit update codes for the fetch/decode, decode/execute and execute/writeback pipeline registers, plus the PC enable and the redirect select.
- It resolves multi-cycle execute waits, load-use hazards, taken-branch/jump redirects, external stalls and the stop/halt condition.
- Update code encoding: 2'b01 advance, 2'b10 flush (insert bubble), 2'b00 hold.

---
 rtl/pipe_hazard_ctrl_if.sv | 40 ++++
 rtl/pipe_hazard_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline control bundle: hazard inputs from D/E stages and
// per-stage register update codes back to the datapath.
interface pipe_hazard_ctrl_if #(
    parameter int WAIT_W = 5
);
    logic [5:0]        d_rs;
    logic [5:0]        d_rt;
    logic              d_uses_s;
    logic              d_uses_t;
    logic [1:0]        de_rw;
    logic [4:0]        de_rd;
    logic              de_is_load;
    logic [WAIT_W-1:0] de_wait_time;
    logic              e_redirect;
    logic              de_stop;
    logic              ext_stall;
    logic              resume;
    logic [1:0]        fd_update;
    logic [1:0]        de_update;
    logic [1:0]        ew_update;
    logic              pc_en;
    logic              pc_redirect;
    logic              halted;

    modport master (
        output d_rs, d_rt, d_uses_s, d_uses_t,
        output de_rw, de_rd, de_is_load, de_wait_time,
        output e_redirect, de_stop, ext_stall, resume,
        input  fd_update, de_update, ew_update,
        input  pc_en, pc_redirect, halted
    );

    modport slave (
        input  d_rs, d_rt, d_uses_s, d_uses_t,
        input  de_rw, de_rd, de_is_load, de_wait_time,
        input  e_redirect, de_stop, ext_stall, resume,
        output fd_update, de_update, ew_update,
        output pc_en, pc_redirect, halted
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central F/D/E/W sequencer: multi-cycle execute waits, load-use
// stalls, redirects, external freeze and stop/halt handling.
module pipe_hazard_ctrl #(
    parameter int WAIT_W = 5
) (
    input  logic              clk,
    input  logic              rstn,
    pipe_hazard_ctrl_if.slave bus
);
    localparam logic [1:0] UPD_HOLD  = 2'b00;
    localparam logic [1:0] UPD_ADV   = 2'b01;
    localparam logic [1:0] UPD_FLUSH = 2'b10;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [WAIT_W-1:0] cnt;
    logic [WAIT_W-1:0] cnt_n;
    logic              waited;
    logic              waited_n;

    logic              haz_s;
    logic              haz_t;
    logic              load_use;
    logic              need_wait;

    logic [1:0]        fd;
    logic [1:0]        de;
    logic [1:0]        ew;
    logic              pc_en;
    logic              pc_redirect;
    logic              halted;

    // The register file select bit must match as well as the index.
    always_comb begin
        haz_s = bus.d_uses_s
              && (bus.de_rw != 2'b00)
              && (bus.de_rw[1] == bus.d_rs[5])
              && (bus.de_rd == bus.d_rs[4:0]);
        haz_t = bus.d_uses_t
              && (bus.de_rw != 2'b00)
              && (bus.de_rw[1] == bus.d_rt[5])
              && (bus.de_rd == bus.d_rt[4:0]);
        load_use  = bus.de_is_load && (haz_s || haz_t);
        need_wait = (bus.de_wait_time != '0) && !waited;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= RUN;
            cnt    <= '0;
            waited <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            waited <= waited_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        waited_n    = waited;
        fd          = UPD_ADV;
        de          = UPD_ADV;
        ew          = UPD_ADV;
        pc_en       = 1'b1;
        pc_redirect = 1'b0;
        halted      = 1'b0;

        unique case (state)
            RUN: begin
                if (bus.ext_stall) begin
                    fd    = UPD_HOLD;
                    de    = UPD_HOLD;
                    ew    = UPD_HOLD;
                    pc_en = 1'b0;
                end else if (need_wait) begin
                    fd    = UPD_HOLD;
                    de    = UPD_HOLD;
                    ew    = UPD_FLUSH;
                    pc_en = 1'b0;
                    // This cycle is the first stall cycle of N.
                    if (bus.de_wait_time == WAIT_W'(1)) begin
                        waited_n = 1'b1;
                    end else begin
                        cnt_n   = bus.de_wait_time - WAIT_W'(1);
                        state_n = WAIT;
                    end
                end else if (bus.de_stop) begin
                    fd      = UPD_FLUSH;
                    de      = UPD_FLUSH;
                    pc_en   = 1'b0;
                    state_n = HALT;
                end else if (bus.e_redirect) begin
                    fd          = UPD_FLUSH;
                    de          = UPD_FLUSH;
                    pc_redirect = 1'b1;
                end else if (load_use) begin
                    fd    = UPD_HOLD;
                    de    = UPD_FLUSH;
                    pc_en = 1'b0;
                end
            end
            WAIT: begin
                fd    = UPD_HOLD;
                de    = UPD_HOLD;
                ew    = UPD_FLUSH;
                pc_en = 1'b0;
                if (!bus.ext_stall) begin
                    cnt_n = cnt - WAIT_W'(1);
                    if (cnt == WAIT_W'(1)) begin
                        state_n  = RUN;
                        waited_n = 1'b1;
                    end
                end
            end
            HALT: begin
                fd     = UPD_HOLD;
                de     = UPD_HOLD;
                ew     = UPD_HOLD;
                pc_en  = 1'b0;
                halted = 1'b1;
                if (bus.resume) begin
                    fd      = UPD_FLUSH;
                    de      = UPD_FLUSH;
                    state_n = RUN;
                end
            end
            default: begin
                state_n = RUN;
            end
        endcase

        // Once D/E moves the E instruction is a new one.
        if (de != UPD_HOLD) begin
            waited_n = 1'b0;
        end
    end

    assign bus.fd_update   = fd;
    assign bus.de_update   = de;
    assign bus.ew_update   = ew;
    assign bus.pc_en       = pc_en;
    assign bus.pc_redirect = pc_redirect;
    assign bus.halted      = halted;
endmodule
